inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction queue between the IF stage (PC + instruction ROM) and the ID stage.
- Buffers fetched {pc, instruction} pairs, decouples ID stalls from fetch, and throttles the PC via a stall output.
- Owns branch-redirect timing for the MIPS delay slot:
  - the delay-slot word is always kept before the redirect is issued to the PC;
  - sequential words beyond the delay slot are discarded.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  exception flush; discards all state.
- fetch_valid  input  1  fresh {fetch_pc, fetch_inst} presented this cycle. IF asserts it only once per fetched word.
- fetch_pc  input  32  address of the fetched word.
- fetch_inst  input  32  ROM read data.
- stall_fetch  output  1  to PC stall_pc; high when count >= DEPTH-1.
- pc_branch_flag  output  1  to PC branch_flag; combinational.
- pc_branch_addr  output  32  to PC branch_addr; combinational.
- id_valid  output  1  head entry valid (count != 0).
- id_pc  output  32  head pc.
- id_inst  output  32  head instruction.
- stall_id  input  1  ID not accepting; head is held.
- id_branch_flag  input  1  head instruction is a taken branch/jump. Qualified by id_valid && !stall_id.
- id_branch_addr  input  32  its target.
- count  output  PTR_W+1  occupancy.
- overflow  output  1  sticky; set when fetch_valid arrives while count == DEPTH.

Behaviour:
- Reset (async): all pointers 0, count 0, state NORMAL, saved target 0, overflow 0. All outputs read 0 while in reset.
- Head read: id_pc and id_inst are driven combinationally from storage at the read pointer.
- Pop: id_valid && !stall_id. Pop latency from push is 1 cycle; a word pushed at edge N is visible at the head after edge N.
- Push: fetch_valid && count < DEPTH, in state NORMAL or DS_PENDING. When count == DEPTH the word is dropped and overflow is set.
- Simultaneous push and pop: count unchanged. A push into a full queue with a same-cycle pop is still dropped; the push test uses the registered count.
- Pointers wrap modulo DEPTH.
- stall_fetch = (count >= DEPTH-1). This leaves one slot free for the in-flight ROM word.
- State machine, two states: NORMAL and DS_PENDING.
- Taken branch at a pop with id_branch_flag = 1 in NORMAL:
  - count >= 2: keep only entry head+1 (the delay slot). Drop all other entries and any same-cycle push. Next count = 1. Assert pc_branch_flag = 1 and pc_branch_addr = id_branch_addr this cycle.
  - count == 1 and fetch_valid = 1: the pushed word becomes the delay slot. Next count = 1. Redirect asserted this cycle.
  - count == 1 and fetch_valid = 0: save the target and go to DS_PENDING. Next count = 0. No redirect yet.
- DS_PENDING:
  - id_valid = 0, so no new branch can arrive.
  - On the first fetch_valid: push it, assert pc_branch_flag with the saved target in the same cycle, then return to NORMAL.
- pc_branch_flag is 0 in every other case.
- flush overrides everything in the same cycle:
  - next count 0, pointers 0, state NORMAL;
  - same-cycle push and branch ignored;
  - pc_branch_flag forced to 0;
  - overflow is not cleared (only rst clears it).
- stall_id with id_branch_flag set has no effect; the branch is evaluated only at the pop.

Decomposition:
- Shared header (with the existing bus and pc definitions):
  - ADDR_BUS/DATA_BUS widths;
  - state encodings IFQ_NORMAL and IFQ_DS_PENDING.
- One sub-module, ifq_storage: DEPTH x 64-bit register array with write port plus asynchronous read port at the head and head+1.
- Control, pointers, count and FSM stay in inst_fetch_queue.

Test Plan:
- Reset mid-stream: push 3 words, assert rst asynchronously between edges -> count = 0, id_valid = 0, overflow = 0 immediately.
- Fill/back-pressure: stall_id = 1, push pcs 0x100, 0x104, 0x108 -> stall_fetch rises when count = 3. Push 0x10C -> count = 4. Push 0x110 -> dropped, overflow = 1.
- Streaming: stall_id = 0, fetch_valid every cycle, pcs 0x200 upward -> id_pc sequence 0x200, 0x204, … with a 1-cycle lag; count stays 1.
- Branch with count = 3 (0x300 branch, 0x304, 0x308) plus a same-cycle push of 0x30C, target 0x400:
  - pc_branch_flag = 1 and pc_branch_addr = 0x400 in the pop cycle;
  - next head = 0x304 with count = 1; 0x308 and 0x30C gone.
- Branch with count = 1, no fetch: DS_PENDING is entered and pc_branch_flag = 0. Next fetch of 0x504 -> pc_branch_flag = 1 with the saved target 0x600 that cycle, then head = 0x504.
- Flush during DS_PENDING with a simultaneous push -> count = 0, state NORMAL, no redirect, push discarded.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: bus widths, the
// queue FSM state encoding and the stored {pc, instruction} entry layout.
package inst_fetch_queue_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int ENTRY_W  = ADDR_BUS + DATA_BUS;

  // Queue control state: normal streaming, or waiting for the delay-slot word
  typedef enum logic [0:0] {
    IFQ_NORMAL     = 1'b0,
    IFQ_DS_PENDING = 1'b1
  } ifq_state_e;

  // One queue entry as seen by ID
  typedef struct packed {
    logic [ADDR_BUS-1:0] pc;
    logic [DATA_BUS-1:0] inst;
  } ifq_entry_t;

  // Builds an entry from the IF stage outputs
  function automatic ifq_entry_t make_entry(input logic [ADDR_BUS-1:0] pc,
                                            input logic [DATA_BUS-1:0] inst);
    ifq_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_storage.sv
// Register-array storage for the fetch queue: one write port and two
// asynchronous read ports (head and head+1, the delay slot after a branch).
module ifq_storage
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  ifq_entry_t       wdata,
  input  logic [PTR_W-1:0] head_addr,
  output ifq_entry_t       head_data,
  output ifq_entry_t       next_data
);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] next_addr;

  // head+1 wraps naturally because DEPTH is a power of two
  assign next_addr = head_addr + PTR_W'(1);

  // Array write; cleared on reset so the head reads zero while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign head_data = mem[head_addr];
  assign next_data = mem[next_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between IF and ID. Buffers {pc, inst} pairs, throttles
// the PC and times branch redirects so the delay-slot word is always kept.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                fetch_valid,
  input  logic [ADDR_BUS-1:0] fetch_pc,
  input  logic [DATA_BUS-1:0] fetch_inst,
  output logic                stall_fetch,
  output logic                pc_branch_flag,
  output logic [ADDR_BUS-1:0] pc_branch_addr,
  output logic                id_valid,
  output logic [ADDR_BUS-1:0] id_pc,
  output logic [DATA_BUS-1:0] id_inst,
  input  logic                stall_id,
  input  logic                id_branch_flag,
  input  logic [ADDR_BUS-1:0] id_branch_addr,
  output logic [PTR_W:0]      count,
  output logic                overflow
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_HIGH = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);

  ifq_state_e          state, state_nx;
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_nx;
  logic [PTR_W-1:0]    wr_ptr, wr_ptr_nx;
  logic [PTR_W:0]      count_nx;
  logic [ADDR_BUS-1:0] saved_target, saved_target_nx;
  logic                overflow_nx;
  logic                we;
  logic                do_pop;
  logic                has_room;
  ifq_entry_t          head_entry;
  ifq_entry_t          next_entry;

  ifq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (wr_ptr),
    .wdata     (make_entry(fetch_pc, fetch_inst)),
    .head_addr (rd_ptr),
    .head_data (head_entry),
    .next_data (next_entry)
  );

  // The delay-slot entry is reached through the head+1 read port only by
  // advancing rd_ptr; the data itself is not needed in the control path.
  logic unused_next;
  assign unused_next = ^next_entry;

  assign id_valid    = (count != '0);
  assign id_pc       = head_entry.pc;
  assign id_inst     = head_entry.inst;
  // One slot stays free for the ROM word already in flight
  assign stall_fetch = (count >= CNT_HIGH);
  assign do_pop      = id_valid && !stall_id;
  assign has_room    = (count != CNT_FULL);
  assign overflow_nx = overflow | (fetch_valid && (count == CNT_FULL));

  // Next-state, pointer/count update and redirect outputs
  always_comb begin
    state_nx        = state;
    rd_ptr_nx       = rd_ptr;
    wr_ptr_nx       = wr_ptr;
    count_nx        = count;
    saved_target_nx = saved_target;
    we              = 1'b0;
    pc_branch_flag  = 1'b0;
    pc_branch_addr  = '0;

    if (flush) begin
      state_nx  = IFQ_NORMAL;
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
      count_nx  = '0;
    end else begin
      case (state)
        IFQ_NORMAL: begin
          if (do_pop && id_branch_flag) begin
            if (count >= CNT_TWO) begin
              // Keep only head+1 (delay slot); drop the rest and any push
              rd_ptr_nx      = rd_ptr + PTR_ONE;
              wr_ptr_nx      = rd_ptr + PTR_TWO;
              count_nx       = CNT_ONE;
              pc_branch_flag = 1'b1;
              pc_branch_addr = id_branch_addr;
            end else if (fetch_valid) begin
              // The word arriving now is the delay slot
              we             = 1'b1;
              wr_ptr_nx      = wr_ptr + PTR_ONE;
              rd_ptr_nx      = rd_ptr + PTR_ONE;
              count_nx       = CNT_ONE;
              pc_branch_flag = 1'b1;
              pc_branch_addr = id_branch_addr;
            end else begin
              // Delay slot not fetched yet: hold the redirect until it is
              rd_ptr_nx       = rd_ptr + PTR_ONE;
              count_nx        = '0;
              saved_target_nx = id_branch_addr;
              state_nx        = IFQ_DS_PENDING;
            end
          end else begin
            we = fetch_valid && has_room;
            if (we) begin
              wr_ptr_nx = wr_ptr + PTR_ONE;
            end else begin
              wr_ptr_nx = wr_ptr;
            end
            if (do_pop) begin
              rd_ptr_nx = rd_ptr + PTR_ONE;
            end else begin
              rd_ptr_nx = rd_ptr;
            end
            case ({we, do_pop})
              2'b10:   count_nx = count + CNT_ONE;
              2'b01:   count_nx = count - CNT_ONE;
              default: count_nx = count;
            endcase
          end
        end
        IFQ_DS_PENDING: begin
          if (fetch_valid) begin
            we             = 1'b1;
            wr_ptr_nx      = wr_ptr + PTR_ONE;
            count_nx       = count + CNT_ONE;
            pc_branch_flag = 1'b1;
            pc_branch_addr = saved_target;
            state_nx       = IFQ_NORMAL;
          end else begin
            state_nx = IFQ_DS_PENDING;
          end
        end
        default: begin
          state_nx = IFQ_NORMAL;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IFQ_NORMAL;
    end else begin
      state <= state_nx;
    end
  end

  // Pointers, occupancy, saved branch target and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      saved_target <= '0;
      overflow     <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_nx;
      wr_ptr       <= wr_ptr_nx;
      count        <= count_nx;
      saved_target <= saved_target_nx;
      overflow     <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        stall_fetch;
  logic        pc_branch_flag;
  logic [31:0] pc_branch_addr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        stall_id;
  logic        id_branch_flag;
  logic [31:0] id_branch_addr;
  logic [PTR_W:0] count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .stall_fetch(stall_fetch), .pc_branch_flag(pc_branch_flag),
    .pc_branch_addr(pc_branch_addr), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .stall_id(stall_id), .id_branch_flag(id_branch_flag),
    .id_branch_addr(id_branch_addr), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    fetch_valid    = 1'b0;
    fetch_pc       = 32'h0;
    fetch_inst     = 32'h0;
    stall_id       = 1'b1;
    id_branch_flag = 1'b0;
    id_branch_addr = 32'h0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic push_word(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_inst  = ~pc;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_fetch); end
    n_checks++; if (pc_branch_flag !== 1'b0 || pc_branch_addr !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %b/%h want 0/0", pc_branch_flag, pc_branch_addr); end
    n_checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", id_pc, id_inst); end
    reset_dut();
  endtask

  task automatic test_fill();
    reset_dut();
    stall_id = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_word(32'h100 + 32'(4 * k));
      @(negedge clk);
      n_checks++; if (count !== 3'((k + 1 > DEPTH) ? DEPTH : k + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, count, (k + 1 > DEPTH) ? DEPTH : k + 1); end
      n_checks++; if (stall_fetch !== (k + 1 >= DEPTH - 1)) begin n_fail++; $display("FAIL fill_stall[%0d]: got %b", k, stall_fetch); end
      n_checks++; if (overflow !== (k == DEPTH)) begin n_fail++; $display("FAIL fill_overflow[%0d]: got %b", k, overflow); end
      n_checks++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL fill_head[%0d]: got %h want 100", k, id_pc); end
    end
  endtask

  // Runs right after test_fill: queue is full and overflow is set
  task automatic test_reset_midstream();
    stall_id = 1'b0;
    step();
    stall_id = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got count %0d ovf %b want 3/1", count, overflow); end
    step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", count); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_id_valid: got %b want 0", id_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    reset_dut();
    stall_id = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h200 + 32'(4 * k);
      fetch_inst  = ~fetch_pc;
      @(negedge clk);
      if (k > 0) begin
        n_checks++; if (id_pc !== 32'h200 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, id_pc, 32'h200 + 32'(4 * (k - 1))); end
        n_checks++; if (id_inst !== ~(32'h200 + 32'(4 * (k - 1)))) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h", k, id_inst); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", k, count); end
      end
      step();
    end
    fetch_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (id_pc !== 32'h21C) begin n_fail++; $display("FAIL stream_last: got %h want 21c", id_pc); end
    step();
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_drain: got %0d want 0", count); end
  endtask

  task automatic test_branch_count3();
    reset_dut();
    stall_id = 1'b1;
    push_word(32'h300);
    push_word(32'h304);
    push_word(32'h308);
    stall_id       = 1'b0;
    id_branch_flag = 1'b1;
    id_branch_addr = 32'h400;
    fetch_valid    = 1'b1;
    fetch_pc       = 32'h30C;
    fetch_inst     = ~32'h30C;
    @(negedge clk);
    n_checks++; if (pc_branch_flag !== 1'b1 || pc_branch_addr !== 32'h400) begin n_fail++; $display("FAIL br3_redirect: got %b/%h want 1/400", pc_branch_flag, pc_branch_addr); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (count !== 3'd1 || id_pc !== 32'h304) begin n_fail++; $display("FAIL br3_head: got count %0d pc %h want 1/304", count, id_pc); end
    n_checks++; if (pc_branch_flag !== 1'b0) begin n_fail++; $display("FAIL br3_flag_drop: got %b want 0", pc_branch_flag); end
    stall_id = 1'b0;
    step();
    stall_id = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL br3_gone: got count %0d valid %b want 0/0", count, id_valid); end
  endtask

  // Leaves the DUT in DS_PENDING with saved target 0x600
  task automatic enter_pending();
    reset_dut();
    push_word(32'h500);
    stall_id       = 1'b0;
    id_branch_flag = 1'b1;
    id_branch_addr = 32'h600;
    @(negedge clk);
    n_checks++; if (pc_branch_flag !== 1'b0) begin n_fail++; $display("FAIL br1_no_redirect: got %b want 0", pc_branch_flag); end
    step();
    idle_inputs();
  endtask

  task automatic test_branch_count1();
    enter_pending();
    @(negedge clk);
    n_checks++; if (count !== 3'd0 || id_valid !== 1'b0 || pc_branch_flag !== 1'b0) begin n_fail++; $display("FAIL br1_pending: got count %0d valid %b flag %b", count, id_valid, pc_branch_flag); end
    step();
    fetch_valid = 1'b1;
    fetch_pc    = 32'h504;
    fetch_inst  = ~32'h504;
    @(negedge clk);
    n_checks++; if (pc_branch_flag !== 1'b1 || pc_branch_addr !== 32'h600) begin n_fail++; $display("FAIL br1_redirect: got %b/%h want 1/600", pc_branch_flag, pc_branch_addr); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (id_pc !== 32'h504 || count !== 3'd1) begin n_fail++; $display("FAIL br1_head: got pc %h count %0d want 504/1", id_pc, count); end
    n_checks++; if (pc_branch_flag !== 1'b0) begin n_fail++; $display("FAIL br1_flag_drop: got %b want 0", pc_branch_flag); end
  endtask

  task automatic test_flush_pending();
    enter_pending();
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h704;
    fetch_inst  = ~32'h704;
    @(negedge clk);
    n_checks++; if (pc_branch_flag !== 1'b0) begin n_fail++; $display("FAIL flush_redirect: got %b want 0", pc_branch_flag); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_count: got %0d valid %b want 0/0", count, id_valid); end
    step();
    fetch_valid = 1'b1;
    fetch_pc    = 32'h708;
    fetch_inst  = ~32'h708;
    @(negedge clk);
    n_checks++; if (pc_branch_flag !== 1'b0) begin n_fail++; $display("FAIL flush_state_normal: got flag %b want 0", pc_branch_flag); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h708) begin n_fail++; $display("FAIL flush_after_push: got valid %b pc %h want 1/708", id_valid, id_pc); end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] keep;
    logic        pending;
    logic [31:0] saved;
    logic        ovf;
    logic [31:0] next_pc;
    logic        exp_flag;
    logic [31:0] exp_addr;
    int          sz;
    logic        popped;
    logic        push_ok;
    reset_dut();
    pending = 1'b0;
    saved   = 32'h0;
    ovf     = 1'b0;
    next_pc = 32'h1000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      flush          = ($urandom_range(0, 29) == 0);
      fetch_valid    = ($urandom_range(0, 2) != 0);
      fetch_pc       = next_pc;
      fetch_inst     = $urandom;
      stall_id       = ($urandom_range(0, 2) == 0);
      id_branch_flag = ($urandom_range(0, 3) == 0);
      id_branch_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
      if (fetch_valid) next_pc = next_pc + 32'd4;
      @(negedge clk);
      sz       = q.size();
      exp_flag = 1'b0;
      exp_addr = 32'h0;
      if (!flush) begin
        if (pending) begin
          if (fetch_valid) begin exp_flag = 1'b1; exp_addr = saved; end
        end else if (sz != 0 && !stall_id && id_branch_flag && (sz >= 2 || fetch_valid)) begin
          exp_flag = 1'b1;
          exp_addr = id_branch_addr;
        end
      end
      n_checks++; if (count !== 3'(sz)) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, sz); end
      n_checks++; if (id_valid !== (sz != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, id_valid, sz != 0); end
      n_checks++; if (stall_fetch !== (sz >= DEPTH - 1)) begin n_fail++; $display("FAIL rnd_stall@%0d: got %b", cyc, stall_fetch); end
      n_checks++; if (overflow !== ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %b want %b", cyc, overflow, ovf); end
      n_checks++; if (pc_branch_flag !== exp_flag || pc_branch_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_redirect@%0d: got %b/%h want %b/%h", cyc, pc_branch_flag, pc_branch_addr, exp_flag, exp_addr); end
      if (sz != 0) begin
        n_checks++; if ({id_pc, id_inst} !== q[0]) begin n_fail++; $display("FAIL rnd_head@%0d: got %h want %h", cyc, {id_pc, id_inst}, q[0]); end
      end
      // Reference model update for this edge
      if (fetch_valid && sz == DEPTH) ovf = 1'b1;
      if (flush) begin
        q.delete();
        pending = 1'b0;
      end else if (pending) begin
        if (fetch_valid) begin
          q.push_back({fetch_pc, fetch_inst});
          pending = 1'b0;
        end
      end else begin
        popped  = (sz != 0) && !stall_id;
        push_ok = fetch_valid && (sz < DEPTH);
        if (popped && id_branch_flag && sz >= 2) begin
          keep = q[1];
          q.delete();
          q.push_back(keep);
        end else begin
          if (popped) void'(q.pop_front());
          if (push_ok) q.push_back({fetch_pc, fetch_inst});
          if (popped && id_branch_flag && !fetch_valid) begin
            pending = 1'b1;
            saved   = id_branch_addr;
          end
        end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reset_midstream();
    test_stream();
    test_branch_count3();
    test_branch_count1();
    test_flush_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
